// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch stage (read-only) and the data stage.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data always wins over fetch.
module mem_port_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          flush_if,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_fetch,
  output logic          stall_mem,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  // Counter value seen on the edge that closes the last allowed BUSY cycle.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t        state_reg, state_next;
  logic [7:0]    wait_cnt_reg, wait_cnt_next;
  logic          cancel_reg, cancel_next;
  logic          mem_req_reg, mem_req_next;
  logic          mem_we_reg, mem_we_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DW-1:0] if_rdata_reg, if_rdata_next;
  logic [DW-1:0] dm_rdata_reg, dm_rdata_next;
  logic          if_valid_reg, if_valid_next;
  logic          dm_valid_reg, dm_valid_next;
  logic          err_reg, err_next;

  logic if_elig, dm_elig, pick_dm, timeout, fetch_dropped;

  assign if_elig = if_req & ~if_valid_reg & ~flush_if;
  assign dm_elig = dm_req & ~dm_valid_reg;

`ifdef MEM_ARB_RR_EN
  // last_grant_reg: 1 = data was granted last, 0 = fetch (reset value).
  logic last_grant_reg, last_grant_next;

  assign pick_dm = dm_elig & (~if_elig | ~last_grant_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= 1'b0;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    last_grant_next = last_grant_reg;
    if (state_reg == IDLE) begin
      if (pick_dm) begin
        last_grant_next = 1'b1;
      end else if (if_elig) begin
        last_grant_next = 1'b0;
      end
    end
  end
`else
  assign pick_dm = dm_elig;
`endif

  assign timeout       = (wait_cnt_reg == WAIT_LAST);
  assign fetch_dropped = cancel_reg | flush_if;

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    cancel_next    = cancel_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    dm_rdata_next  = dm_rdata_reg;
    if_valid_next  = 1'b0;
    dm_valid_next  = 1'b0;
    err_next       = err_reg;

    case (state_reg)
      IDLE: begin
        mem_req_next = 1'b0;
        if (pick_dm) begin
          state_next     = DM_BUSY;
          mem_req_next   = 1'b1;
          mem_we_next    = dm_we;
          mem_addr_next  = dm_addr;
          mem_wdata_next = dm_wdata;
          wait_cnt_next  = '0;
          cancel_next    = 1'b0;
        end else if (if_elig) begin
          state_next    = IF_BUSY;
          mem_req_next  = 1'b1;
          mem_we_next   = 1'b0;
          mem_addr_next = if_addr;
          wait_cnt_next = '0;
          cancel_next   = 1'b0;
        end
      end

      IF_BUSY, DM_BUSY: begin
        if (mem_ack || timeout) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          if (!mem_ack) begin
            err_next = 1'b1;
          end
          if (state_reg == IF_BUSY) begin
            // A fetch cancelled by a branch completes silently on the bus.
            if (!fetch_dropped) begin
              if_valid_next = 1'b1;
              if_rdata_next = mem_ack ? mem_rdata : '0;
            end
          end else begin
            dm_valid_next = 1'b1;
            if (!mem_ack) begin
              dm_rdata_next = '0;
            end else if (!mem_we_reg) begin
              dm_rdata_next = mem_rdata;
            end
          end
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
          if (state_reg == IF_BUSY && flush_if) begin
            cancel_next = 1'b1;
          end
        end
      end

      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      cancel_reg    <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      if_valid_reg  <= 1'b0;
      dm_valid_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      cancel_reg    <= cancel_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdata_reg  <= dm_rdata_next;
      if_valid_reg  <= if_valid_next;
      dm_valid_reg  <= dm_valid_next;
      err_reg       <= err_next;
    end
  end

  assign mem_req     = mem_req_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign if_rdata    = if_rdata_reg;
  assign if_valid    = if_valid_reg;
  assign dm_rdata    = dm_rdata_reg;
  assign dm_valid    = dm_valid_reg;
  assign err         = err_reg;
  assign stall_fetch = if_req & ~if_valid_reg;
  assign stall_mem   = dm_req & ~dm_valid_reg;

endmodule
